// File: rtl/exec_unit_pkg.sv
// Shared opcode constants, divider state encoding and opcode helpers for exec_unit.
package exec_unit_pkg;

   localparam logic [4:0] ALU_OP_ADD  = 5'd0;
   localparam logic [4:0] ALU_OP_SUB  = 5'd1;
   localparam logic [4:0] ALU_OP_AND  = 5'd2;
   localparam logic [4:0] ALU_OP_OR   = 5'd3;
   localparam logic [4:0] ALU_OP_XOR  = 5'd4;
   localparam logic [4:0] ALU_OP_SLL  = 5'd5;
   localparam logic [4:0] ALU_OP_SRL  = 5'd6;
   localparam logic [4:0] ALU_OP_SRA  = 5'd7;
   localparam logic [4:0] ALU_OP_SLT  = 5'd8;
   localparam logic [4:0] ALU_OP_SLTU = 5'd9;
   localparam logic [4:0] ALU_OP_MUL  = 5'd10;
   localparam logic [4:0] ALU_OP_DIV  = 5'd11;
   localparam logic [4:0] ALU_OP_DIVU = 5'd12;
   localparam logic [4:0] ALU_OP_REM  = 5'd13;
   localparam logic [4:0] ALU_OP_REMU = 5'd14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   function automatic logic is_div_op(input logic [4:0] op);
      return (op == ALU_OP_DIV) || (op == ALU_OP_DIVU) ||
             (op == ALU_OP_REM) || (op == ALU_OP_REMU);
   endfunction

   function automatic logic is_signed_div(input logic [4:0] op);
      return (op == ALU_OP_DIV) || (op == ALU_OP_REM);
   endfunction

   function automatic logic is_rem_op(input logic [4:0] op);
      return (op == ALU_OP_REM) || (op == ALU_OP_REMU);
   endfunction

endpackage

// File: rtl/exec_unit_div_iter.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
module div_iter
   import exec_unit_pkg::*;
#(
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        last,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam int CW = $clog2(DIV_STEPS);

   logic [CW-1:0] count;
   logic [31:0]   divisor_q;
   logic [32:0]   shifted;
   logic [32:0]   diff;

   // quotient doubles as the dividend shift register
   assign shifted = {remainder, quotient[31]};
   assign diff    = shifted - {1'b0, divisor_q};
   assign last    = busy && (count == '0);

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         busy      <= 1'b0;
         count     <= '0;
         quotient  <= 32'h0;
         remainder <= 32'h0;
         divisor_q <= 32'h0;
      end else if (start) begin
         busy      <= 1'b1;
         count     <= CW'(DIV_STEPS - 1);
         quotient  <= dividend;
         remainder <= 32'h0;
         divisor_q <= divisor;
      end else if (busy) begin
         if (!diff[32]) begin
            remainder <= diff[31:0];
            quotient  <= {quotient[30:0], 1'b1};
         end else begin
            remainder <= shifted[31:0];
            quotient  <= {quotient[30:0], 1'b0};
         end
         if (count == '0) busy <= 1'b0;
         else             count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU/MUL ops plus a multi-cycle divide/remainder path.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | ready; single-cycle ops complete here, divides start
//   ST_RUN  | div_iter stepping, counter 31 down to 0
//   ST_DONE | sign fix-up / divide-by-zero result, pulse next cycle
module exec_unit
   import exec_unit_pkg::*;
#(
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [4:0]  alu_op_i,
   input  logic [31:0] oprand_a_i,
   input  logic [31:0] oprand_b_i,
   input  logic [4:0]  wd_i,
   input  logic        wen_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        result_valid_o,
   output logic [31:0] result_o,
   output logic [4:0]  wd_o,
   output logic        wen_o
);

   div_state_e  state;
   logic        accept;
   logic        div_op;
   logic        sgn_op;
   logic        b_zero;
   logic        div_start;
   logic        div_busy;
   logic        div_last;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] alu_res;
   logic [31:0] div_res;

   logic [4:0]  wd_q;
   logic        wen_q;
   logic        dz_q;
   logic        is_rem_q;
   logic        neg_q_q;
   logic        neg_r_q;
   logic [31:0] a_q;

   assign busy_o    = (state != ST_IDLE);
   assign accept    = valid_i && !busy_o && !flush_i;
   assign div_op    = is_div_op(alu_op_i);
   assign sgn_op    = is_signed_div(alu_op_i);
   assign b_zero    = (oprand_b_i == 32'h0);
   assign div_start = accept && div_op && !b_zero;
   assign a_mag     = (sgn_op && oprand_a_i[31]) ? -oprand_a_i : oprand_a_i;
   assign b_mag     = (sgn_op && oprand_b_i[31]) ? -oprand_b_i : oprand_b_i;

   div_iter #(.DIV_STEPS(DIV_STEPS)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .abort     (flush_i),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .busy      (div_busy),
      .last      (div_last),
      .quotient  (quo),
      .remainder (rem)
   );

   always_comb begin
      alu_res = 32'h0;
      case (alu_op_i)
         ALU_OP_ADD:  alu_res = oprand_a_i + oprand_b_i;
         ALU_OP_SUB:  alu_res = oprand_a_i - oprand_b_i;
         ALU_OP_AND:  alu_res = oprand_a_i & oprand_b_i;
         ALU_OP_OR:   alu_res = oprand_a_i | oprand_b_i;
         ALU_OP_XOR:  alu_res = oprand_a_i ^ oprand_b_i;
         ALU_OP_SLL:  alu_res = oprand_a_i << oprand_b_i[4:0];
         ALU_OP_SRL:  alu_res = oprand_a_i >> oprand_b_i[4:0];
         ALU_OP_SRA:  alu_res = $unsigned($signed(oprand_a_i) >>> oprand_b_i[4:0]);
         ALU_OP_SLT:  alu_res = {31'h0, $signed(oprand_a_i) < $signed(oprand_b_i)};
         ALU_OP_SLTU: alu_res = {31'h0, oprand_a_i < oprand_b_i};
         ALU_OP_MUL:  alu_res = oprand_a_i * oprand_b_i;
         default:     alu_res = 32'h0;
      endcase
   end

   // divide by zero bypasses the divider, so no sign fix-up applies
   always_comb begin
      div_res = 32'h0;
      if (dz_q)          div_res = is_rem_q ? a_q : 32'hFFFF_FFFF;
      else if (is_rem_q) div_res = neg_r_q ? -rem : rem;
      else               div_res = neg_q_q ? -quo : quo;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         result_valid_o <= 1'b0;
         result_o       <= 32'h0;
         wd_o           <= 5'h0;
         wen_o          <= 1'b0;
         wd_q           <= 5'h0;
         wen_q          <= 1'b0;
         dz_q           <= 1'b0;
         is_rem_q       <= 1'b0;
         neg_q_q        <= 1'b0;
         neg_r_q        <= 1'b0;
         a_q            <= 32'h0;
      end else begin
         result_valid_o <= 1'b0;
         if (flush_i) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     if (div_op) begin
                        wd_q     <= wd_i;
                        wen_q    <= wen_i;
                        dz_q     <= b_zero;
                        is_rem_q <= is_rem_op(alu_op_i);
                        neg_q_q  <= sgn_op && (oprand_a_i[31] ^ oprand_b_i[31]);
                        neg_r_q  <= sgn_op && oprand_a_i[31];
                        a_q      <= oprand_a_i;
                        state    <= b_zero ? ST_DONE : ST_RUN;
                     end else begin
                        result_o       <= alu_res;
                        result_valid_o <= 1'b1;
                        wd_o           <= wd_i;
                        wen_o          <= wen_i;
                     end
                  end
               end
               ST_RUN: begin
                  if (div_last) state <= ST_DONE;
               end
               ST_DONE: begin
                  result_o       <= div_res;
                  result_valid_o <= 1'b1;
                  wd_o           <= wd_q;
                  wen_o          <= wen_q;
                  state          <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: latency, result, busy window, flush and reset abort.
module tb_exec_unit;
   import exec_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [4:0]  alu_op_i = 5'h0;
   logic [31:0] oprand_a_i = 32'h0;
   logic [31:0] oprand_b_i = 32'h0;
   logic [4:0]  wd_i = 5'h0;
   logic        wen_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        busy_o;
   logic        result_valid_o;
   logic [31:0] result_o;
   logic [4:0]  wd_o;
   logic        wen_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exec_unit #(.DIV_STEPS(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (valid_i),
      .alu_op_i       (alu_op_i),
      .oprand_a_i     (oprand_a_i),
      .oprand_b_i     (oprand_b_i),
      .wd_i           (wd_i),
      .wen_i          (wen_i),
      .flush_i        (flush_i),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o),
      .wd_o           (wd_o),
      .wen_o          (wen_o)
   );

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      bit          poke;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // accepted at the posedge ending cycle T; returns just after that edge
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wen);
      @(negedge clk);
      valid_i = 1'b1; alu_op_i = op; oprand_a_i = a; oprand_b_i = b; wd_i = wd; wen_i = wen;
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic run_op(input string tag, input vec_t v, input logic [4:0] wd, input logic wen);
      int first = 0, busy_cnt = 0, pulses = 0;
      logic [31:0] res = 32'h0;
      logic [4:0]  wd_seen = 5'h0;
      logic        wen_seen = 1'b0;
      issue(v.op, v.a, v.b, wd, wen);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (busy_o) busy_cnt++;
         if (result_valid_o) begin
            pulses++;
            if (first == 0) begin
               first = k; res = result_o; wd_seen = wd_o; wen_seen = wen_o;
            end
         end
         // operation offered while busy must be ignored
         if (v.poke && k == 3) begin
            valid_i = 1'b1; alu_op_i = ALU_OP_ADD; oprand_a_i = 32'h1; oprand_b_i = 32'h1;
         end
         if (v.poke && k == 4) valid_i = 1'b0;
      end
      chk({tag, " res"}, res, v.exp);
      chk({tag, " lat"}, first, v.lat);
      chk({tag, " busy"}, busy_cnt, v.lat - 1);
      chk({tag, " pulses"}, pulses, 1);
      chk({tag, " wd"}, {27'h0, wd_seen}, {27'h0, wd});
      chk({tag, " wen"}, {31'h0, wen_seen}, {31'h0, wen});
   endtask

   initial begin
      int pulses;
      vecs.push_back('{ALU_OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1, 0});
      vecs.push_back('{ALU_OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 1, 0});
      vecs.push_back('{ALU_OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 0});
      vecs.push_back('{ALU_OP_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1, 0});
      vecs.push_back('{ALU_OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1, 0});
      vecs.push_back('{ALU_OP_SLL,  32'h1,         32'h24,        32'h10,        1, 0});
      vecs.push_back('{ALU_OP_SRL,  32'h8000_0000, 32'd31,        32'h1,         1, 0});
      vecs.push_back('{ALU_OP_SRA,  32'h8000_0000, 32'h21,        32'hC000_0000, 1, 0});
      vecs.push_back('{ALU_OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1, 0});
      vecs.push_back('{ALU_OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0});
      vecs.push_back('{ALU_OP_MUL,  32'h1_2345,    32'h100,       32'h123_4500,  1, 0});
      vecs.push_back('{ALU_OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1, 0});
      vecs.push_back('{5'h1F,       32'h1234_5678, 32'h1,         32'h0,         1, 0});
      vecs.push_back('{ALU_OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1});
      vecs.push_back('{ALU_OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0});
      vecs.push_back('{ALU_OP_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 2, 0});
      vecs.push_back('{ALU_OP_REMU, 32'd100,       32'd0,         32'd100,       2, 0});
      vecs.push_back('{ALU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0});
      vecs.push_back('{ALU_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         34, 0});
      vecs.push_back('{ALU_OP_DIVU, 32'd100,       32'd7,         32'd14,        34, 0});
      vecs.push_back('{ALU_OP_REMU, 32'd100,       32'd7,         32'd2,         34, 0});
      vecs.push_back('{ALU_OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         34, 0});
      vecs.push_back('{ALU_OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0});

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst busy",  {31'h0, busy_o}, 32'h0);
      chk("rst valid", {31'h0, result_valid_o}, 32'h0);
      chk("rst result", result_o, 32'h0);
      chk("rst wd",    {27'h0, wd_o}, 32'h0);
      chk("rst wen",   {31'h0, wen_o}, 32'h0);
      rst = 1'b0;

      foreach (vecs[i])
         run_op($sformatf("v%0d", i), vecs[i], 5'(i + 1), 1'(i % 2));

      // flush and valid together: flush wins, nothing accepted
      @(negedge clk);
      valid_i = 1'b1; flush_i = 1'b1; alu_op_i = ALU_OP_ADD; oprand_a_i = 32'd3; oprand_b_i = 32'd4;
      @(posedge clk); #1;
      valid_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      chk("flushprio valid", {31'h0, result_valid_o}, 32'h0);

      // flush at T+10 of a divide, ADD accepted at T+11
      issue(ALU_OP_DIV, 32'd1000, 32'd3, 5'd9, 1'b1);
      repeat (9) @(negedge clk);
      @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      chk("flush busy",  {31'h0, busy_o}, 32'h0);
      chk("flush valid", {31'h0, result_valid_o}, 32'h0);
      valid_i = 1'b1; alu_op_i = ALU_OP_ADD; oprand_a_i = 32'd20; oprand_b_i = 32'd22; wd_i = 5'd4; wen_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      chk("flush add valid", {31'h0, result_valid_o}, 32'h1);
      chk("flush add res", result_o, 32'd42);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (result_valid_o) pulses++;
      end
      chk("flush no result", pulses, 0);

      // reset at T+5 of a divide
      issue(ALU_OP_DIVU, 32'd500, 32'd5, 5'd7, 1'b1);
      repeat (4) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort busy",   {31'h0, busy_o}, 32'h0);
      chk("abort valid",  {31'h0, result_valid_o}, 32'h0);
      chk("abort result", result_o, 32'h0);
      chk("abort wd",     {27'h0, wd_o}, 32'h0);
      chk("abort wen",    {31'h0, wen_o}, 32'h0);
      rst = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (result_valid_o) pulses++;
      end
      chk("abort no result", pulses, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
